// File: rtl/msg_schedule.sv
// msg_schedule: SHA-256 message schedule generator.
// Captures 16 message words in LOAD, then emits W[0..NUM_WORDS-1] in EXPAND
// using a sliding 16-word window.
// Optional feature macro: MSG_SCHEDULE_ABORT_EN adds an 'abort' input that
// discards the current block (same effect as rst, lower priority than rst).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   abort           (MSG_SCHEDULE_ABORT_EN only) discard current block
//   in_valid/in_ready/in_word     message word input handshake
//   out_valid/out_ready/out_word/out_index  schedule word output handshake
//   done            one-cycle pulse after the last schedule word is accepted
module msg_schedule #(
  parameter int unsigned NUM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
`ifdef MSG_SCHEDULE_ABORT_EN
  input  logic        abort,
`endif
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_index,
  output logic        done
);

  localparam int unsigned WORD_W = 32;
  localparam int unsigned WIN_N  = 16;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned IDX_W  = 6;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIN_N - 1);
  localparam logic [IDX_W-1:0] LAST_T   = IDX_W'(NUM_WORDS - 1);

  typedef enum logic {
    S_LOAD   = 1'b0,
    S_EXPAND = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [IDX_W-1:0]    t_q;
  logic [WORD_W-1:0]   win_q [WIN_N];
  logic                done_q;

  logic                in_hs_c;
  logic                out_hs_c;
  logic                shift_c;
  logic [WORD_W-1:0]   fill_c;
  logic [WORD_W-1:0]   new_w_c;
  logic                abort_c;

`ifdef MSG_SCHEDULE_ABORT_EN
  assign abort_c = abort;
`else
  assign abort_c = 1'b0;
`endif

  // Small sigma functions of the SHA-256 schedule
  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    sig0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    sig1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

  // Next schedule word appended at the top of the window
  assign new_w_c = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];

  // Next-state and handshake decode
  always_comb begin
    state_d  = state_q;
    in_hs_c  = 1'b0;
    out_hs_c = 1'b0;
    case (state_q)
      S_LOAD: begin
        in_hs_c = in_valid;
        if (in_valid && (cnt_q == LAST_CNT)) state_d = S_EXPAND;
      end
      S_EXPAND: begin
        out_hs_c = out_ready;
        if (out_ready && (t_q == LAST_T)) state_d = S_LOAD;
      end
      default: state_d = S_LOAD;
    endcase
  end

  // Both handshakes shift the window; only the fill word differs
  assign shift_c = in_hs_c | out_hs_c;
  assign fill_c  = in_hs_c ? in_word : new_w_c;

  // State, counters and window
  always_ff @(posedge clk) begin
    if (rst || abort_c) begin
      state_q <= S_LOAD;
      cnt_q   <= '0;
      t_q     <= '0;
      done_q  <= 1'b0;
      for (int k = 0; k < WIN_N; k++) win_q[k] <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= out_hs_c && (t_q == LAST_T);
      if (shift_c) begin
        for (int k = 0; k < WIN_N - 1; k++) win_q[k] <= win_q[k+1];
        win_q[WIN_N-1] <= fill_c;
      end
      if (in_hs_c) cnt_q <= cnt_q + CNT_W'(1);
      if (out_hs_c) t_q <= (t_q == LAST_T) ? '0 : t_q + IDX_W'(1);
    end
  end

  assign in_ready  = (state_q == S_LOAD);
  assign out_valid = (state_q == S_EXPAND);
  assign out_word  = win_q[0];
  assign out_index = t_q;
  assign done      = done_q;

endmodule

// File: tb/tb_msg_schedule.sv
// tb_msg_schedule: directed, self-checking bench for msg_schedule.
// Expected schedules come from a reference recurrence over W[t-2..t-16];
// known SHA-256 "abc" words are checked from a constant table.
module tb_msg_schedule;

  localparam int NW = 64;

  typedef logic [31:0] msg_t  [16];
  typedef logic [31:0] warr_t [64];
  typedef struct {
    int          t;
    logic [31:0] w;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_word;
  logic [5:0]  out_index;
  logic        done;
`ifdef MSG_SCHEDULE_ABORT_EN
  logic        abort = 1'b0;
`endif

  int n_run  = 0;
  int n_fail = 0;

  msg_schedule dut (
    .clk       (clk),
    .rst       (rst),
`ifdef MSG_SCHEDULE_ABORT_EN
    .abort     (abort),
`endif
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_index (out_index),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] s0(input logic [31:0] x);
    s0 = ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] s1(input logic [31:0] x);
    s1 = ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  function automatic warr_t model(input msg_t m);
    warr_t w;
    for (int t = 0; t < 16; t++) w[t] = m[t];
    for (int t = 16; t < 64; t++) w[t] = s1(w[t-2]) + w[t-7] + s0(w[t-15]) + w[t-16];
    return w;
  endfunction

  // Called at a negedge; ends at the negedge after the 16th input handshake.
  task automatic load_block(input msg_t m, input bit hold, input logic [31:0] hold_word);
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_word  = m[i];
      check("load_ready", 32'(in_ready), 32'd1);
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = hold;
    in_word  = hold ? hold_word : 32'd0;
  endtask

  // Called right after load_block; ends at the negedge of the done pulse.
  task automatic collect(input warr_t exp, input bit rnd, output warr_t got);
    int          n;
    int          cyc;
    int          dones;
    bit          stalled;
    logic [31:0] pw;
    logic [5:0]  pi;
    n = 0; cyc = 0; dones = 0; stalled = 1'b0; pw = '0; pi = '0;
    for (int k = 0; k < NW; k++) got[k] = '0;
    check("first_valid", 32'(out_valid), 32'd1);
    while (n < NW && cyc < 2000) begin
      check("expand_valid", 32'(out_valid), 32'd1);
      if (stalled) begin
        check("stall_word", out_word, pw);
        check("stall_index", 32'(out_index), 32'(pi));
      end
      if (done) dones++;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        check($sformatf("word_W%0d", n), out_word, exp[n]);
        check($sformatf("index_%0d", n), 32'(out_index), 32'(n));
        got[n]  = out_word;
        n++;
        stalled = 1'b0;
      end else begin
        stalled = out_valid;
        pw      = out_word;
        pi      = out_index;
      end
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("collect_timeout", 32'(n), 32'(NW));
    check("done_early", 32'(dones), 32'd0);
    check("done_pulse", 32'(done), 32'd1);
    check("done_in_ready", 32'(in_ready), 32'd1);
    check("done_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    vec_t  tbl [7];
    msg_t  abc, zero, blk2, blk3;
    warr_t got, zexp;
    int    cyc;

    tbl[0] = '{0,  32'h61626380};
    tbl[1] = '{1,  32'h00000000};
    tbl[2] = '{14, 32'h00000000};
    tbl[3] = '{15, 32'h00000018};
    tbl[4] = '{16, 32'h61626380};
    tbl[5] = '{17, 32'h000F0000};
    tbl[6] = '{18, 32'h7DA86405};

    for (int i = 0; i < 16; i++) begin
      abc[i]  = 32'd0;
      zero[i] = 32'd0;
      blk2[i] = 32'(i + 1) * 32'h9E3779B9;
      blk3[i] = ~(32'(i) * 32'h01010101) ^ 32'h5A5A0F0F;
    end
    abc[0]  = 32'h61626380;
    abc[15] = 32'h00000018;
    for (int t = 0; t < NW; t++) zexp[t] = 32'd0;

    // Reset
    rst = 1'b1; in_valid = 1'b0; in_word = 32'd0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_out_word", out_word, 32'd0);
    check("rst_out_index", 32'(out_index), 32'd0);

    // "abc" block, consumer always ready, plus known-answer table
    load_block(abc, 1'b0, 32'd0);
    collect(model(abc), 1'b0, got);
    for (int i = 0; i < 7; i++)
      check($sformatf("abc_tbl_W%0d", tbl[i].t), got[tbl[i].t], tbl[i].w);
    @(negedge clk);
    check("abc_done_once", 32'(done), 32'd0);

    // All-zero block
    load_block(zero, 1'b0, 32'd0);
    collect(zexp, 1'b0, got);
    @(negedge clk);
    check("zero_done_once", 32'(done), 32'd0);

    // "abc" with random backpressure
    load_block(abc, 1'b0, 32'd0);
    collect(model(abc), 1'b1, got);
    for (int i = 0; i < 7; i++)
      check($sformatf("rnd_tbl_W%0d", tbl[i].t), got[tbl[i].t], tbl[i].w);
    out_ready = 1'b0;
    @(negedge clk);
    check("rnd_done_once", 32'(done), 32'd0);

    // Back-to-back blocks with in_valid held high through expansion
    load_block(abc, 1'b1, blk2[0]);
    collect(model(abc), 1'b0, got);
    load_block(blk2, 1'b0, 32'd0);
    collect(model(blk2), 1'b0, got);
    @(negedge clk);
    check("b2b_done_once", 32'(done), 32'd0);

    // Reset at t=20 discards the block
    load_block(blk3, 1'b0, 32'd0);
    out_ready = 1'b1;
    cyc = 0;
    while (out_index != 6'd20 && cyc < 200) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    check("reach_t20", 32'(out_index), 32'd20);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_index", 32'(out_index), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    @(negedge clk);
    check("mid_rst_no_done", 32'(done), 32'd0);
    load_block(blk3, 1'b0, 32'd0);
    collect(model(blk3), 1'b0, got);
    @(negedge clk);

`ifdef MSG_SCHEDULE_ABORT_EN
    // Abort at load count 7, with a competing input handshake
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1;
      in_word  = blk2[i];
      @(posedge clk);
      @(negedge clk);
    end
    abort    = 1'b1;
    in_word  = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    abort    = 1'b0;
    in_valid = 1'b0;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    load_block(abc, 1'b0, 32'd0);
    collect(model(abc), 1'b0, got);
    @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
